// File: rtl/mem_boot_loader_pkg.sv
// Shared types and constants for the lab8 byte-stream program loader.
package mem_boot_loader_pkg;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned DEF_AW  = 8;
    localparam int unsigned CNT_W   = 9;
    localparam logic [7:0]  DEF_HDR = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        HI,
        LO,
        CSUM,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/mem_boot_loader.sv
// Framed byte-stream loader: writes 16-bit words into RAM and holds the CPU in reset until done.
// Optional trailing XOR checksum byte is compiled in with LOADER_CHECKSUM_EN.
module mem_boot_loader
    import mem_boot_loader_pkg::*;
#(
    parameter int unsigned   AW   = DEF_AW,
    parameter logic [AW-1:0] BASE = '0,
    parameter logic [7:0]    HDR  = DEF_HDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              start,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              cpu_reset,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  words_loaded
);

    state_t           state;
    logic [CNT_W-1:0] frame_len;
    logic [7:0]       hi_byte;
    logic             take;
    logic [CNT_W-1:0] idx_next;

    assign take     = in_valid && in_ready;
    assign idx_next = words_loaded + CNT_W'(1);

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] acc;
`else
    assign err = 1'b0;
`endif

    // words_loaded doubles as the word index within the frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            cpu_reset    <= 1'b1;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            done         <= 1'b0;
            words_loaded <= '0;
            frame_len    <= '0;
            hi_byte      <= '0;
`ifdef LOADER_CHECKSUM_EN
            err          <= 1'b0;
            acc          <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (take && in_data == HDR) state <= COUNT;
                end
                COUNT: begin
                    if (take) begin
                        frame_len    <= (in_data == 8'h00) ? CNT_W'(256) : CNT_W'(in_data);
                        words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
                        acc          <= '0;
`endif
                        state        <= HI;
                    end
                end
                HI: begin
                    if (take) begin
                        hi_byte <= in_data;
`ifdef LOADER_CHECKSUM_EN
                        acc     <= acc ^ in_data;
`endif
                        state   <= LO;
                    end
                end
                LO: begin
                    if (take) begin
                        wr_en        <= 1'b1;
                        wr_addr      <= BASE + AW'(words_loaded);
                        wr_data      <= {hi_byte, in_data};
                        words_loaded <= idx_next;
`ifdef LOADER_CHECKSUM_EN
                        acc          <= acc ^ in_data;
                        state        <= (idx_next == frame_len) ? CSUM : HI;
`else
                        if (idx_next == frame_len) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                            in_ready  <= 1'b0;
                        end else begin
                            state <= HI;
                        end
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: begin
                    if (take) begin
                        in_ready <= 1'b0;
                        if (in_data == acc) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                DONE, ERR: begin
                    if (start) begin
                        state        <= IDLE;
                        in_ready     <= 1'b1;
                        cpu_reset    <= 1'b1;
                        done         <= 1'b0;
                        words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
                        err          <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
